// File: rtl/lobster_fetch.sv
// lobster_fetch: sequential instruction prefetcher feeding a small in-order queue.
// Keeps one SRAM read outstanding at a time. A redirect from the executor flushes
// the queue and restarts fetching at the 8-byte-aligned target.
// Optional build macro: LOBSTER_FETCH_PERF_EN adds the perf_words/perf_flush
// saturating event counters.
module lobster_fetch #(
    parameter int unsigned           ADDR_WIDTH = 36,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 36'hF800
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  mem_ce,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rdy,
    input  logic [63:0]           mem_data,
    input  logic                  redir_valid,
    input  logic [ADDR_WIDTH-1:0] redir_pc,
    output logic                  inst_valid,
    output logic [63:0]           inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready
`ifdef LOBSTER_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_words,
    output logic [15:0]           perf_flush
`endif
);

    localparam int unsigned           PTR_W      = $clog2(DEPTH);
    localparam int unsigned           CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   fetch_pc;
    logic [ADDR_WIDTH-1:0]   fetch_next;
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic                    addr_load;
    logic [ADDR_WIDTH-1:0]   redir_al;
    logic [ADDR_WIDTH-1:0]   pc_inc;

    logic [63:0]             q_data [DEPTH];
    logic [ADDR_WIDTH-1:0]   q_pc   [DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_after_push;
    logic                    push;
    logic                    pop;

    assign redir_al         = redir_pc & ALIGN_MASK;
    assign pc_inc           = fetch_pc + STEP;
    assign pop              = inst_valid & inst_ready & ~redir_valid;
    assign count_after_push = count + CNT_W'(1) - CNT_W'(pop);

    assign inst_valid = (count != '0);
    assign inst_data  = q_data[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

    // Fetch FSM state, fetch pointer and the held request address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_next;
            if (addr_load) begin
                mem_addr <= addr_next;
            end
        end
    end

    // Next-state, request strobe and push decision. A new request is only
    // issued while a queue slot is free, which reserves room for its response.
    always_comb begin
        state_next = state;
        fetch_next = fetch_pc;
        addr_load  = 1'b0;
        addr_next  = fetch_pc;
        push       = 1'b0;
        mem_ce     = 1'b0;
        case (state)
            IDLE: begin
                if (redir_valid) begin
                    fetch_next = redir_al;
                    addr_load  = 1'b1;
                    addr_next  = redir_al;
                    state_next = REQ;
                end else if (count < DEPTH_C) begin
                    addr_load  = 1'b1;
                    addr_next  = fetch_pc;
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_ce = 1'b1;
                if (redir_valid) begin
                    fetch_next = redir_al;
                    if (mem_rdy) begin
                        // Response is stale: drop it and restart immediately.
                        addr_load  = 1'b1;
                        addr_next  = redir_al;
                        state_next = REQ;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (mem_rdy) begin
                    push       = 1'b1;
                    fetch_next = pc_inc;
                    if (count_after_push < DEPTH_C) begin
                        addr_load = 1'b1;
                        addr_next = pc_inc;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                mem_ce = 1'b1;
                if (redir_valid) begin
                    fetch_next = redir_al;
                end
                if (mem_rdy) begin
                    // Queue was flushed on entry, so a slot is always free here.
                    addr_load  = 1'b1;
                    addr_next  = fetch_next;
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Prefetch queue storage and occupancy; a redirect flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_data[i[PTR_W-1:0]] <= '0;
                q_pc[i[PTR_W-1:0]]   <= '0;
            end
        end else if (redir_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_data[wr_ptr] <= mem_data;
                q_pc[wr_ptr]   <= mem_addr;
                wr_ptr         <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

`ifdef LOBSTER_FETCH_PERF_EN
    // Saturating counters of accepted words and redirect events.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_words <= '0;
            perf_flush <= '0;
        end else begin
            if (push && (perf_words != '1)) begin
                perf_words <= perf_words + 32'd1;
            end
            if (redir_valid && (perf_flush != '1)) begin
                perf_flush <= perf_flush + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lobster_fetch.sv
// Self-checking bench for lobster_fetch: directed scenarios followed by a
// randomized run checked against an instruction-stream model.
module tb_lobster_fetch;

    localparam int unsigned AW    = 36;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_ce;
    logic [AW-1:0] mem_addr;
    logic          mem_rdy;
    logic [63:0]   mem_data;
    logic          redir_valid;
    logic [AW-1:0] redir_pc;
    logic          inst_valid;
    logic [63:0]   inst_data;
    logic [AW-1:0] inst_pc;
    logic          inst_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // Memory contents: each address holds a word that encodes that address.
    function automatic logic [63:0] word_of(input logic [AW-1:0] a);
        return {28'hA5C3E17, a};
    endfunction

    assign mem_data = word_of(mem_addr);

    always #5 clk = ~clk;

    lobster_fetch #(
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .RESET_PC  (36'hF800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_ce     (mem_ce),
        .mem_addr   (mem_addr),
        .mem_rdy    (mem_rdy),
        .mem_data   (mem_data),
        .redir_valid(redir_valid),
        .redir_pc   (redir_pc),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst         = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        mem_rdy     = 1'b0;
        inst_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : main
        logic [63:0]   stale;
        int            pushes;
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] prev_addr;
        logic          prev_ce;
        logic          prev_rdy;
        logic          prev_redir;
        int            pops;

        // Reset, with a stray memory response that must be ignored
        rst         = 1'b1;
        redir_valid = 1'b0;
        redir_pc    = '0;
        mem_rdy     = 1'b1;
        inst_ready  = 1'b0;
        tick();
        tick();
        chk("rst_mem_ce", mem_ce, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_pc", inst_pc, 0);

        // Streaming after reset release, memory always ready, consumer always ready
        rst        = 1'b0;
        inst_ready = 1'b1;
        chk("stream_idle_first", mem_ce, 0);
        tick();
        chk("stream_ce0", mem_ce, 1);
        chk("stream_addr0", mem_addr, 36'hF800);
        chk("stream_valid0", inst_valid, 0);
        tick();
        chk("stream_addr1", mem_addr, 36'hF808);
        chk("stream_valid1", inst_valid, 1);
        chk("stream_pc1", inst_pc, 36'hF800);
        chk("stream_data1", inst_data, word_of(36'hF800));
        tick();
        chk("stream_addr2", mem_addr, 36'hF810);
        chk("stream_pc2", inst_pc, 36'hF808);

        // Consumer stalled: queue fills to DEPTH, fetching stops, head holds
        reset_dut();
        mem_rdy = 1'b1;
        pushes  = 0;
        for (int i = 0; i < 12; i++) begin
            if (mem_ce && mem_rdy) pushes++;
            if (inst_valid) chk("full_head_hold", inst_data, word_of(36'hF800));
            tick();
        end
        chk("full_push_count", pushes, DEPTH);
        chk("full_mem_ce", mem_ce, 0);
        chk("full_valid", inst_valid, 1);
        chk("full_pc", inst_pc, 36'hF800);

        // Free one slot, then redirect coinciding with a response and a pop
        inst_ready = 1'b1;
        tick();
        chk("full_pop_idle", mem_ce, 0);
        chk("full_pop_pc", inst_pc, 36'hF808);
        inst_ready = 1'b0;
        tick();
        chk("refill_ce", mem_ce, 1);
        chk("refill_addr", mem_addr, 36'hF820);
        redir_valid = 1'b1;
        redir_pc    = 36'h567C;
        mem_rdy     = 1'b1;
        inst_ready  = 1'b1;
        tick();
        chk("coin_flush_valid", inst_valid, 0);
        chk("coin_ce", mem_ce, 1);
        chk("coin_addr", mem_addr, 36'h5678);
        redir_valid = 1'b0;
        tick();
        chk("coin_valid", inst_valid, 1);
        chk("coin_pc", inst_pc, 36'h5678);
        chk("coin_data", inst_data, word_of(36'h5678));
        chk("coin_next_addr", mem_addr, 36'h5680);

        // Redirect while a request waits: the stale response is drained
        reset_dut();
        inst_ready = 1'b1;
        stale      = word_of(36'hF800);
        tick();
        chk("drain_req_ce", mem_ce, 1);
        chk("drain_req_addr", mem_addr, 36'hF800);
        redir_valid = 1'b1;
        redir_pc    = 36'h1234;
        tick();
        redir_valid = 1'b0;
        chk("drain_ce", mem_ce, 1);
        chk("drain_addr", mem_addr, 36'hF800);
        chk("drain_valid", inst_valid, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drain_hold_ce", mem_ce, 1);
            chk("drain_hold_addr", mem_addr, 36'hF800);
            chk("drain_no_stale", inst_data == stale, 0);
        end
        mem_rdy = 1'b1;
        tick();
        chk("drain_done_ce", mem_ce, 1);
        chk("drain_new_addr", mem_addr, 36'h1230);
        chk("drain_dropped", inst_valid, 0);
        chk("drain_no_stale2", inst_data == stale, 0);
        tick();
        chk("drain_first_valid", inst_valid, 1);
        chk("drain_first_pc", inst_pc, 36'h1230);
        chk("drain_first_data", inst_data, word_of(36'h1230));

        // Redirect from IDLE to the top of the address space, then wrap
        reset_dut();
        redir_valid = 1'b1;
        redir_pc    = 36'hFFFFFFFFF;
        mem_rdy     = 1'b1;
        tick();
        chk("wrap_ce", mem_ce, 1);
        chk("wrap_addr", mem_addr, 36'hFFFFFFFF8);
        chk("wrap_valid0", inst_valid, 0);
        redir_valid = 1'b0;
        tick();
        chk("wrap_next_addr", mem_addr, 36'h0);
        chk("wrap_pc", inst_pc, 36'hFFFFFFFF8);
        chk("wrap_valid1", inst_valid, 1);

        // Reset in the middle of a request, late response pulse afterwards
        reset_dut();
        tick();
        mem_rdy = 1'b1;
        tick();
        chk("mid_setup_valid", inst_valid, 1);
        mem_rdy = 1'b0;
        rst     = 1'b1;
        tick();
        chk("mid_rst_ce", mem_ce, 0);
        chk("mid_rst_valid", inst_valid, 0);
        chk("mid_rst_addr", mem_addr, 0);
        rst     = 1'b0;
        mem_rdy = 1'b1;
        tick();
        chk("mid_restart_ce", mem_ce, 1);
        chk("mid_restart_addr", mem_addr, 36'hF800);
        chk("mid_no_push", inst_valid, 0);
        mem_rdy = 1'b0;
        tick();
        chk("mid_no_push2", inst_valid, 0);
        chk("mid_hold_addr", mem_addr, 36'hF800);

        // Randomized run: the consumer must see a contiguous +8 stream that
        // restarts at the aligned target after every redirect
        reset_dut();
        exp_pc     = 36'hF800;
        prev_ce    = 1'b0;
        prev_rdy   = 1'b0;
        prev_redir = 1'b0;
        prev_addr  = '0;
        pops       = 0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) chk("rnd_flush", inst_valid, 0);
            if (prev_ce && !prev_rdy) begin
                chk("rnd_ce_hold", mem_ce, 1);
                chk("rnd_addr_hold", mem_addr, prev_addr);
            end
            redir_valid = ($urandom_range(0, 39) == 0);
            redir_pc    = AW'({$urandom(), $urandom()});
            mem_rdy     = ($urandom_range(0, 2) == 0);
            inst_ready  = ($urandom_range(0, 1) == 1);
            if (inst_valid && inst_ready && !redir_valid) begin
                chk("rnd_pc", inst_pc, exp_pc);
                chk("rnd_data", inst_data, word_of(exp_pc));
                exp_pc = exp_pc + AW'(8);
                pops++;
            end
            if (redir_valid) exp_pc = redir_pc & ~AW'(7);
            prev_ce    = mem_ce;
            prev_rdy   = mem_rdy;
            prev_addr  = mem_addr;
            prev_redir = redir_valid;
            tick();
        end
        chk("rnd_progress", pops > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
